uart_tx_fifo: RTL

Parametrised UART transmitter that replaces the fixed 8N1, divided-clock transmitter.
- Runs entirely in the `clock` domain, using a baud-tick counter instead of a derived clock.
- Frame format is configurable: data width, parity and stop bits.
- Bytes are queued in a small FIFO, so frames go out back-to-back.
- Sits between the host/register interface and the serial pin.

---
 rtl/uart_tx_fifo.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with a configurable frame format
// (data bits, optional even/odd parity, 1 or 2 stop bits) fed by a small
// transmit FIFO. Everything runs in the `clock` domain; bit timing comes
// from a baud counter rather than a derived clock, and queued words go out
// back-to-back with no idle gap between frames.
module uart_tx_fifo #(
  parameter int unsigned CLK_FREQ   = 10000000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clock,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [DATA_BITS-1:0]          wr_data,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          tx,
  output logic                          busy,
  output logic                          donetx
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH);
  localparam int unsigned IDX_W        = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
  localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic             PAR_ODD   = (PARITY_ODD != 0);
  localparam bit               HAS_PAR   = (PARITY_EN != 0);

  // Reject configurations the datapath cannot represent.
  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("uart_tx_fifo: CLK_FREQ/BAUD_RATE must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_tx_fifo: DATA_BITS must be in 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two, at least 2");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // FIFO storage and bookkeeping
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]       count_q, count_d;
  logic                 full_q, full_d;
  logic                 push, pop, empty;
  logic [DATA_BITS-1:0] head;

  // Transmit state
  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 donetx_q, donetx_d;
  logic                 bit_end;

  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign bit_end = (cnt_q == CNT_LAST);

  // Frame sequencing: decide the next line level and when to pop the FIFO.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned, which would infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    tx_d     = tx_q;
    donetx_d = 1'b0;
    pop      = 1'b0;

    unique case (state_q)
      IDLE: begin
        tx_d  = 1'b1;
        cnt_d = '0;
        idx_d = '0;
        pop   = !empty;
      end
      START: begin
        if (bit_end) begin
          cnt_d   = '0;
          idx_d   = '0;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == DATA_LAST) begin
            idx_d = '0;
            if (HAS_PAR) begin
              tx_d    = parity_q;
              state_d = PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = STOP;
            end
          end else begin
            idx_d   = idx_q + 1'b1;
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          idx_d   = '0;
          tx_d    = 1'b1;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == STOP_LAST) begin
            idx_d    = '0;
            donetx_d = 1'b1;
            tx_d     = 1'b1;
            state_d  = IDLE;
            pop      = !empty;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase

    // Starting a frame looks the same from IDLE and from the end of STOP.
    if (pop) begin
      shift_d  = head;
      parity_d = (^head) ^ PAR_ODD;
      tx_d     = 1'b0;
      cnt_d    = '0;
      idx_d    = '0;
      state_d  = START;
    end

    busy_d = (state_d != IDLE);
  end

  // FIFO pointer and occupancy update; a pop frees a slot for a same-cycle write.
  always_comb begin
    push     = wr_en && (!full_q || pop);
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    full_d = (count_d == DEPTH_CNT);
  end

  // FIFO storage write.
  always_ff @(posedge clock) begin
    // NOTE: the storage array is deliberately not reset; the pointers and count decide what is valid.
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      donetx_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      donetx_q <= donetx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign donetx     = donetx_q;
  assign full       = full_q;
  assign fifo_count = count_q;

endmodule
